// File: rtl/icb_multi_arbiter.sv
// ---------------------------------------------------------------------------------------------
// icb_multi_arbiter
//   N-channel request/grant/done arbiter for the shared ICB master port. A winner is chosen
//   while idle, receives a registered one-hot grant, and keeps it until it pulses done or drops
//   its request. Every release is followed by one dead cycle before the next arbitration.
//   Selection is round-robin (PRIO_MODE=0) or fixed priority, lowest index first (PRIO_MODE=1).
//
//   Optional feature macro: MMA_ARB_TIMEOUT_EN
//     Defined   : a watchdog force-releases a grant held for TIMEOUT cycles and sets the
//                 sticky timeout_err flag.
//     Undefined : no watchdog, timeout_err is constant 0, a grant is held indefinitely.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          level request per channel, held until done
//   done         single-cycle completion pulse per channel
//   granted      one-hot registered grant
//   owner_id     index of the current owner; holds its last value while not busy
//   busy         high while a grant is active
//   timeout_err  sticky watchdog flag
// ---------------------------------------------------------------------------------------------
module icb_multi_arbiter #(
    parameter int NUM_CH    = 5,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         granted,
    output logic [$clog2(NUM_CH)-1:0] owner_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDW = $clog2(NUM_CH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT < 2) begin : g_param_check
        $error("icb_multi_arbiter: NUM_CH must be 2..16 and TIMEOUT at least 2");
    end

    logic [1:0]        state_q, state_d;
    logic [NUM_CH-1:0] granted_q, granted_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              busy_q, busy_d;
    logic              win_found;
    logic [IDW-1:0]    win_idx;
    logic              owner_release;
    logic              wd_expire;

    // Winner search: start at rr_ptr (round-robin) or at 0 (fixed priority) and wrap.
    always_comb begin
        int base;
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        base      = (PRIO_MODE != 0) ? 0 : int'(rr_ptr_q);
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = base + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!win_found && req[IDW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    // Only the owner's own done/req matter; everything else is ignored.
    assign owner_release = done[owner_q] | ~req[owner_q] | wd_expire;

    always_comb begin
        state_d   = state_q;
        granted_d = granted_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d            = ST_GRANT;
                    granted_d          = '0;
                    granted_d[win_idx] = 1'b1;
                    owner_d            = win_idx;
                    busy_d             = 1'b1;
                    if (PRIO_MODE == 0) begin
                        rr_ptr_d = (win_idx == IDW'(NUM_CH - 1)) ? '0 : win_idx + IDW'(1);
                    end
                end
            end
            ST_GRANT: begin
                if (owner_release) begin
                    state_d   = ST_RELEASE;
                    granted_d = '0;
                    busy_d    = 1'b0;
                end
            end
            ST_RELEASE: begin
                // Mandatory dead cycle between owners.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            granted_q <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            granted_q <= granted_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

`ifdef MMA_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT);

    logic [WDW-1:0] wd_q, wd_d;
    logic           terr_q, terr_d;

    // Expiry at TIMEOUT-1 releases on the next edge, so a stuck grant lasts TIMEOUT cycles.
    assign wd_expire = (state_q == ST_GRANT) && (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        wd_d   = wd_q;
        terr_d = terr_q | wd_expire;
        if (state_q != ST_GRANT && state_d == ST_GRANT) begin
            wd_d = '0;
        end else if (state_q == ST_GRANT && !owner_release) begin
            wd_d = wd_q + WDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign granted  = granted_q;
    assign owner_id = owner_q;
    assign busy     = busy_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(granted));

endmodule

// File: tb/tb_icb_multi_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_icb_multi_arbiter
//   Two arbiters (round-robin and fixed priority) share one stimulus. A transaction-level model
//   of each is checked every cycle, and directed sequences pin the model with literal values.
// ---------------------------------------------------------------------------------------------
module tb_icb_multi_arbiter;

    localparam int NCH = 5;
    localparam int TMO = 8;
`ifdef MMA_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] g_rr, g_fp;
    logic [2:0] id_rr, id_fp;
    logic       busy_rr, busy_fp, terr_rr, terr_fp;

    int checks = 0;
    int errors = 0;

    icb_multi_arbiter #(.NUM_CH(NCH), .PRIO_MODE(0), .TIMEOUT(TMO)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .granted(g_rr),
        .owner_id(id_rr), .busy(busy_rr), .timeout_err(terr_rr)
    );

    icb_multi_arbiter #(.NUM_CH(NCH), .PRIO_MODE(1), .TIMEOUT(TMO)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .granted(g_fp),
        .owner_id(id_fp), .busy(busy_fp), .timeout_err(terr_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- model: index 0 = round-robin, 1 = fixed priority --------------------------------
    int m_owner[2];   // -1 when nobody holds the port
    int m_last[2];
    int m_cool[2];
    int m_ptr[2];
    int m_cnt[2];
    int m_err[2];

    function automatic int pick(input logic [4:0] r, input int start);
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (start + i) % NCH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_owner[k] = -1;
                m_last[k]  = 0;
                m_cool[k]  = 0;
                m_ptr[k]   = 0;
                m_cnt[k]   = 0;
                m_err[k]   = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_owner[k] >= 0) begin
                    bit tmo;
                    tmo = TO_EN && (m_cnt[k] == TMO - 1);
                    if (done[m_owner[k]] || !req[m_owner[k]] || tmo) begin
                        m_owner[k] = -1;
                        m_cool[k]  = 1;
                        if (tmo) m_err[k] = 1;
                    end else begin
                        m_cnt[k]++;
                    end
                end else if (m_cool[k] != 0) begin
                    m_cool[k] = 0;
                end else if (req != 5'b0) begin
                    int w;
                    w = pick(req, (k == 1) ? 0 : m_ptr[k]);
                    m_owner[k] = w;
                    m_last[k]  = w;
                    m_cnt[k]   = 0;
                    if (k == 0) m_ptr[k] = (w + 1) % NCH;
                end
            end
        end
    end

    // ---- every-cycle comparison against the model ----------------------------------------
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int eg;
            eg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
            check(k == 0 ? "cyc_granted_rr" : "cyc_granted_fp",
                  int'(k == 0 ? g_rr : g_fp), eg);
            check(k == 0 ? "cyc_busy_rr" : "cyc_busy_fp",
                  int'(k == 0 ? busy_rr : busy_fp), (m_owner[k] >= 0) ? 1 : 0);
            check(k == 0 ? "cyc_owner_rr" : "cyc_owner_fp",
                  int'(k == 0 ? id_rr : id_fp), m_last[k]);
            check(k == 0 ? "cyc_terr_rr" : "cyc_terr_fp",
                  int'(k == 0 ? terr_rr : terr_fp), m_err[k]);
        end
    end

    // ---- directed helpers ----------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int k, output int idx, output int waits);
        logic [4:0] g;
        idx   = -1;
        waits = 0;
        for (int n = 0; n < 20 && idx < 0; n++) begin
            tick();
            waits++;
            g = (k == 0) ? g_rr : g_fp;
            for (int b = 0; b < NCH; b++) begin
                if (g[b]) idx = b;
            end
        end
        check("grant_wait", (idx >= 0) ? 1 : 0, 1);
    endtask

    int idx, waits, cnt;
    int rr_exp[4] = '{0, 2, 4, 0};

    initial begin
        // 1. reset with all requests high
        rst_n = 1'b0;
        req   = 5'b11111;
        done  = '0;
        tick();
        tick();
        check("rst_granted", int'(g_rr), 0);
        check("rst_busy", int'(busy_rr), 0);
        check("rst_owner", int'(id_rr), 0);
        rst_n = 1'b1;
        tick();
        check("rst_first_grant_rr", int'(g_rr), 5'b00001);
        check("rst_first_grant_fp", int'(g_fp), 5'b00001);

        // 2. round-robin order with a dead cycle between owners
        do_reset();
        req = 5'b10101;
        for (int k = 0; k < 4; k++) begin
            wait_grant(0, idx, waits);
            check("rr_order", idx, rr_exp[k]);
            if (k > 0) check("rr_gap", waits, 2);
            tick();
            if (idx >= 0) done = 5'(1 << idx);
            tick();
            done = '0;
            check("rr_released", int'(g_rr), 0);
        end

        // 3. fixed priority: ch2 wins until it drops req
        do_reset();
        req = 5'b10100;
        wait_grant(1, idx, waits);
        check("fp_first", idx, 2);
        done = 5'b00100;
        tick();
        done = '0;
        check("fp_released", int'(g_fp), 0);
        wait_grant(1, idx, waits);
        check("fp_regrant", idx, 2);
        check("fp_regrant_gap", waits, 2);
        req = 5'b10000;
        tick();
        check("fp_drop", int'(g_fp), 0);
        wait_grant(1, idx, waits);
        check("fp_ch4", idx, 4);

        // 4. stray done from a non-owner
        do_reset();
        req = 5'b00010;
        wait_grant(0, idx, waits);
        check("stray_owner", idx, 1);
        done = 5'b01000;
        tick();
        done = '0;
        check("stray_granted", int'(g_rr), 5'b00010);
        check("stray_busy", int'(busy_rr), 1);
        tick();
        check("stray_granted2", int'(g_rr), 5'b00010);
        done = 5'b00010;
        tick();
        done = '0;
        check("owner_done_granted", int'(g_rr), 0);
        check("owner_done_busy", int'(busy_rr), 0);

        // 5. asynchronous reset mid-grant, then rr_ptr must be back at 0
        do_reset();
        req = 5'b01000;
        wait_grant(0, idx, waits);
        check("midrst_owner", idx, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_granted", int'(g_rr), 0);
        check("midrst_busy", int'(busy_rr), 0);
        req = 5'b11000;
        tick();
        rst_n = 1'b1;
        wait_grant(0, idx, waits);
        check("midrst_ptr0", idx, 3);

`ifdef MMA_ARB_TIMEOUT_EN
        // 6. watchdog force-release after TMO cycles
        do_reset();
        req = 5'b00011;
        wait_grant(0, idx, waits);
        check("wd_owner", idx, 0);
        cnt = 1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (g_rr != 5'b00001) break;
            cnt++;
        end
        check("wd_hold_cycles", cnt, TMO);
        check("wd_terr", int'(terr_rr), 1);
        wait_grant(0, idx, waits);
        check("wd_next_owner", idx, 1);
        check("wd_next_gap", waits, 2);
        tick();
        tick();
        check("wd_terr_sticky", int'(terr_rr), 1);
`else
        check("terr_tied_rr", int'(terr_rr), 0);
        check("terr_tied_fp", int'(terr_fp), 0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
